ahb_split_slave_mq: RTL
=======================

AHB_SPLIT_SLAVE_MQ -- requirements
Module: ahb_split_slave_mq

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4: number of split-capable masters (2..16).
REQ-002 SHALL have parameter DATA_W, default 32: data width (32 or 64).
REQ-003 SHALL have parameter MEM_WORDS, default 64: backing memory depth (power of 2).
REQ-004 SHALL have parameter SPLIT_DELAY, default 8: countdown cycles before release (1..255).
REQ-005 SHALL have a single clock and a synchronous, active-high reset.
REQ-006 SHALL provide ports: HCLK in 1, clock; HRESET in 1, synchronous active-high reset.
REQ-007 SHALL provide ports: HSEL in 1; HADDR in 32; HTRANS in 2; HWRITE in 1; HSIZE in 3; HWDATA in DATA_W; HREADY in 1, bus ready.
REQ-008 SHALL provide ports: HMASTER in MW = $clog2(NUM_MASTERS), current master ID; HMASTLOCK in 1, locked transfer.
REQ-009 SHALL provide ports: HRDATA out DATA_W; HREADYOUT out 1; HRESP out 2, encoded OKAY=00, ERROR=01, RETRY=10, SPLIT=11; HSPLIT out NUM_MASTERS, per-master release pulse.

Function
REQ-010 SHALL accept an address phase when HSEL & HREADY & HTRANS[1] == 1 (NONSEQ/SEQ), capturing addr, write, master ID.
REQ-011 SHALL ignore IDLE/BUSY transfers and return zero-wait OKAY for them.
REQ-012 SHALL treat a transfer as split-eligible when HMASTLOCK == 0 and ready_mask[HMASTER] == 0.
REQ-013 SHALL complete any transfer that is not split-eligible as zero-wait OKAY.
REQ-014 SHALL give an eligible transfer a two-cycle response: SPLIT1 (HREADYOUT=0, HRESP=SPLIT), then SPLIT2 (HREADYOUT=1, HRESP=SPLIT).
REQ-015 SHALL not access memory for a split transfer.
REQ-016 SHALL use response FSM states IDLE -> SPLIT1 -> SPLIT2 -> IDLE.
REQ-017 SHALL allow a new address phase accepted during SPLIT2 to be processed from IDLE on the next cycle.
REQ-018 SHALL push the master ID into the split FIFO (depth NUM_MASTERS) on entry to SPLIT1 and set queued_mask[ID].
REQ-019 SHALL answer SPLIT again without re-enqueue if the master is already queued, so each master appears at most once and the FIFO cannot overflow.
REQ-020 SHALL run a release engine with states E_IDLE -> E_COUNT -> E_REL.
REQ-021 In E_IDLE, the engine SHALL pop the FIFO head when non-empty and load the counter with SPLIT_DELAY.
REQ-022 In E_COUNT, the engine SHALL decrement the counter and move to E_REL at zero.
REQ-023 In E_REL, the engine SHALL drive HSPLIT[m]=1 for exactly one cycle, set ready_mask[m], clear queued_mask[m] and return to E_IDLE.
REQ-024 SHALL handle a push and a pop in the same cycle correctly, with count unchanged.
REQ-025 SHALL make the release-to-next-pop gap 1 cycle.
REQ-026 SHALL complete a retried transfer from a master with ready_mask[m]=1 as zero-wait OKAY and clear ready_mask[m] in the data phase.
REQ-027 SHALL perform a completed write as mem[HADDR word index] <= HWDATA in the data-phase cycle.
REQ-028 SHALL make HRDATA combinational from mem at the captured index during the data phase, and drive it to 0 otherwise.
REQ-029 SHALL drive HREADYOUT=1 and HRESP=OKAY outside SPLIT states.
REQ-030 SHALL OR together all HSPLIT bits generated in a cycle; only one bit SHALL ever be set.

Reset
REQ-031 SHALL, on HRESET=1 at a rising HCLK, set HREADYOUT=1, HRESP=OKAY, HSPLIT=0, HRDATA=0, both FSMs to IDLE/E_IDLE, FIFO empty, queued_mask=0, ready_mask=0 and counter=0.
REQ-032 SHALL not reset memory contents.
REQ-033 SHALL abandon a reset mid-SPLIT or mid-count without emitting a late HSPLIT.

Configuration
REQ-034 SHALL, with SPLIT_SLV_ERR_EN defined, treat an accepted transfer whose word index >= MEM_WORDS as an ERROR.
REQ-035 An ERROR SHALL use states ERR1 (HREADYOUT=0, HRESP=ERROR) -> ERR2 (HREADYOUT=1, HRESP=ERROR), with no split, enqueue or memory access; ERROR SHALL take priority over split.
REQ-036 SHALL, without SPLIT_SLV_ERR_EN, wrap the address modulo MEM_WORDS, and ERR states SHALL not exist.

Verification
REQ-037 SHALL cover: master 1 NONSEQ write 0x10 -> SPLIT1/SPLIT2; HSPLIT=0b0010 exactly SPLIT_DELAY+2 cycles after push; retry writes 0xA5A5A5A5 with OKAY; read returns it.
REQ-038 SHALL cover: masters 0, 2, 3 split back-to-back -> HSPLIT pulses in order 0b0001, 0b0100, 0b1000, each separated by SPLIT_DELAY+2 cycles.
REQ-039 SHALL cover: HMASTLOCK=1 from master 2 -> zero-wait OKAY, FIFO untouched.
REQ-040 SHALL cover: HRESET asserted in E_COUNT -> no HSPLIT pulse; all masks 0; next transfer from same master is split afresh.
REQ-041 SHALL cover, with SPLIT_SLV_ERR_EN: access at word index MEM_WORDS -> ERR1/ERR2; without it -> OKAY aliasing index 0.
REQ-042 SHALL cover: master already queued re-issues -> SPLIT again, FIFO count unchanged.

Source files
------------

// File: rtl/ahb_split_slave_mq.sv
// ahb_split_slave_mq
// AHB slave with SPLIT support for several masters. Each eligible transfer
// gets a two-cycle SPLIT response and its master is queued in a small FIFO.
// A release engine pops one master at a time and waits SPLIT_DELAY cycles.
// It then pulses HSPLIT for that master and marks it ready, so its retry
// completes with OKAY against the backing memory.
//
// Optional feature: define SPLIT_SLV_ERR_EN to answer out-of-range word
// indices with a two-cycle ERROR. Without it, addresses wrap modulo MEM_WORDS.
//
// Handshake: a transfer is taken when HSEL & HREADY & HTRANS[1] is high and
// this slave is driving HREADYOUT=1. The data phase is the following cycle.
// A low HREADYOUT stalls the bus for that cycle.
//
// Ports
//   HCLK, HRESET       clock, synchronous active-high reset
//   HSEL..HREADY       AHB address/control/write-data inputs
//   HMASTER, HMASTLOCK current master ID, locked transfer
//   HRDATA             read data (0 outside a completed data phase)
//   HREADYOUT, HRESP   transfer response (OKAY/ERROR/RETRY/SPLIT = 00/01/10/11)
//   HSPLIT             one-hot, one-cycle release pulse per master
//   rsp_state_o        response FSM state (debug)
//   eng_state_o        release engine state (debug)
//   fifo_count_o       split FIFO occupancy (debug)
//   ready_mask_o       masters released and allowed to complete (debug)
//   queued_mask_o      masters waiting for release (debug)
module ahb_split_slave_mq #(
    parameter int NUM_MASTERS = 4,
    parameter int DATA_W      = 32,
    parameter int MEM_WORDS   = 64,
    parameter int SPLIT_DELAY = 8,
    localparam int MW         = $clog2(NUM_MASTERS)
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   HSEL,
    input  logic [31:0]            HADDR,
    input  logic [1:0]             HTRANS,
    input  logic                   HWRITE,
    input  logic [2:0]             HSIZE,
    input  logic [DATA_W-1:0]      HWDATA,
    input  logic                   HREADY,
    input  logic [MW-1:0]          HMASTER,
    input  logic                   HMASTLOCK,
    output logic [DATA_W-1:0]      HRDATA,
    output logic                   HREADYOUT,
    output logic [1:0]             HRESP,
    output logic [NUM_MASTERS-1:0] HSPLIT,
    output logic [2:0]             rsp_state_o,
    output logic [1:0]             eng_state_o,
    output logic [MW:0]            fifo_count_o,
    output logic [NUM_MASTERS-1:0] ready_mask_o,
    output logic [NUM_MASTERS-1:0] queued_mask_o
);
    localparam int AW  = $clog2(MEM_WORDS);
    localparam int BSH = $clog2(DATA_W / 8);
    localparam logic [1:0]    RESP_OKAY  = 2'b00;
    localparam logic [1:0]    RESP_SPLIT = 2'b11;
    localparam logic [MW:0]   NM         = (MW + 1)'(NUM_MASTERS);
    localparam logic [MW-1:0] LAST_PTR   = MW'(NUM_MASTERS - 1);
    localparam logic [7:0]    DELAY      = 8'(SPLIT_DELAY);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SPLIT1 = 3'd1,
        S_SPLIT2 = 3'd2
`ifdef SPLIT_SLV_ERR_EN
        ,
        S_ERR1   = 3'd3,
        S_ERR2   = 3'd4
`endif
    } rsp_e;

    typedef enum logic [1:0] {
        E_IDLE  = 2'd0,
        E_COUNT = 2'd1,
        E_REL   = 2'd2
    } eng_e;

    rsp_e                   rsp_q;
    eng_e                   eng_q;
    logic                   hreadyout_q;
    logic [1:0]             hresp_q;
    logic                   dphase_q;
    logic                   dwrite_q;
    logic [AW-1:0]          didx_q;
    logic [MW-1:0]          dmaster_q;
    logic [MW-1:0]          fifo_q [NUM_MASTERS];
    logic [MW-1:0]          wr_q, rd_q, cur_q;
    logic [MW:0]            count_q;
    logic [7:0]             cnt_q;
    logic [NUM_MASTERS-1:0] hsplit_q, ready_mask_q, queued_mask_q;
    logic [DATA_W-1:0]      mem [MEM_WORDS];

    logic [31:0]   word_full;
    logic [AW-1:0] word_idx;
    logic          accept, hm_ok, split_elig, go_err, go_split, go_data, push, pop;
    logic          unused_ok;

    assign word_full  = HADDR >> BSH;
    assign word_idx   = word_full[AW-1:0];
    assign accept     = HSEL & HREADY & HTRANS[1] & hreadyout_q;
    assign hm_ok      = {1'b0, HMASTER} < NM;
    assign split_elig = hm_ok & ~HMASTLOCK & ~ready_mask_q[HMASTER];
`ifdef SPLIT_SLV_ERR_EN
    assign go_err     = accept & (word_full >= 32'(MEM_WORDS));
`else
    assign go_err     = 1'b0;
`endif
    // ERROR wins over SPLIT; an already-queued master is answered SPLIT but not re-enqueued.
    assign go_split   = accept & ~go_err & split_elig;
    assign go_data    = accept & ~go_err & ~split_elig;
    assign push       = go_split & ~queued_mask_q[HMASTER];
    assign pop        = (eng_q == E_IDLE) && (count_q != '0);
    assign unused_ok  = ^{HSIZE, HADDR, word_full};

    function automatic logic [MW-1:0] ptr_inc(input logic [MW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Response FSM. SPLIT2 and ERR2 drive HREADYOUT=1, so they may take the next transfer just like IDLE.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rsp_q       <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= RESP_OKAY;
            dphase_q    <= 1'b0;
            dwrite_q    <= 1'b0;
            didx_q      <= '0;
            dmaster_q   <= '0;
        end else begin
            dphase_q <= go_data;
            if (go_data) begin
                dwrite_q  <= HWRITE;
                didx_q    <= word_idx;
                dmaster_q <= HMASTER;
            end
            case (rsp_q)
                S_SPLIT1: begin
                    rsp_q       <= S_SPLIT2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= RESP_SPLIT;
                end
`ifdef SPLIT_SLV_ERR_EN
                S_ERR1: begin
                    rsp_q       <= S_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 2'b01;
                end
`endif
                default: begin
                    if (go_err) begin
`ifdef SPLIT_SLV_ERR_EN
                        rsp_q       <= S_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= 2'b01;
`endif
                    end else if (go_split) begin
                        rsp_q       <= S_SPLIT1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= RESP_SPLIT;
                    end else begin
                        rsp_q       <= S_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= RESP_OKAY;
                    end
                end
            endcase
        end
    end

    // Split FIFO, master masks and release engine share one block because
    // enqueue and release both update the masks.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            eng_q         <= E_IDLE;
            cnt_q         <= '0;
            cur_q         <= '0;
            hsplit_q      <= '0;
            wr_q          <= '0;
            rd_q          <= '0;
            count_q       <= '0;
            queued_mask_q <= '0;
            ready_mask_q  <= '0;
        end else begin
            hsplit_q <= '0;
            if (push) begin
                fifo_q[wr_q]           <= HMASTER;
                wr_q                   <= ptr_inc(wr_q);
                queued_mask_q[HMASTER] <= 1'b1;
            end
            if (pop) begin
                rd_q <= ptr_inc(rd_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A retried transfer consumes its release.
            if (dphase_q) begin
                ready_mask_q[dmaster_q] <= 1'b0;
            end
            case (eng_q)
                E_IDLE: begin
                    if (pop) begin
                        cur_q <= fifo_q[rd_q];
                        cnt_q <= DELAY;
                        eng_q <= E_COUNT;
                    end
                end
                E_COUNT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == 8'd1) begin
                        eng_q <= E_REL;
                    end
                end
                E_REL: begin
                    hsplit_q[cur_q]      <= 1'b1;
                    ready_mask_q[cur_q]  <= 1'b1;
                    queued_mask_q[cur_q] <= 1'b0;
                    eng_q                <= E_IDLE;
                end
                default: eng_q <= E_IDLE;
            endcase
        end
    end

    // Backing memory is never reset.
    always_ff @(posedge HCLK) begin
        if (!HRESET && dphase_q && dwrite_q) begin
            mem[didx_q] <= HWDATA;
        end
    end

    assign HRDATA        = dphase_q ? mem[didx_q] : '0;
    assign HREADYOUT     = hreadyout_q;
    assign HRESP         = hresp_q;
    assign HSPLIT        = hsplit_q;
    assign rsp_state_o   = rsp_q;
    assign eng_state_o   = eng_q;
    assign fifo_count_o  = count_q;
    assign ready_mask_o  = ready_mask_q;
    assign queued_mask_o = queued_mask_q;

endmodule
